dma_memory_map: RTL and testbench



---
 rtl/dma_mm_pkg.sv | 46 ++++
 rtl/mmio_if.sv | 23 ++
 rtl/dma_mm_channel.sv | 137 +++++++++++++
 rtl/dma_memory_map.sv | 114 +++++++++++
 tb/tb_dma_memory_map.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_mm_pkg.sv
// dma_mm_pkg: shared constants and types for the multi-channel DMA memory map.
//   - register word offsets inside one channel block and the block stride
//   - STATUS bit layout (as a packed struct) and CTRL bit positions
//   - ID register constant builder and cycle counter width/limit
package dma_mm_pkg;

  // Word offsets inside one channel register block (64-bit words, even only).
  localparam logic [15:0] CTRL_OFS    = 16'h0000;
  localparam logic [15:0] RD_ADDR_OFS = 16'h0002;
  localparam logic [15:0] WR_ADDR_OFS = 16'h0004;
  localparam logic [15:0] SIZE_OFS    = 16'h0006;
  localparam logic [15:0] STATUS_OFS  = 16'h0008;
  localparam logic [15:0] CYCLES_OFS  = 16'h000A;

  // Distance between consecutive channel blocks.
  localparam logic [15:0] CH_STRIDE   = 16'h0010;

  // CTRL write bits.
  localparam int CTRL_GO_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // STATUS bit positions.
  localparam int STATUS_DONE_BIT  = 0;
  localparam int STATUS_BUSY_BIT  = 1;
  localparam int STATUS_ERROR_BIT = 2;

  // Field order matches the STATUS bit positions above (error is MSB).
  typedef struct packed {
    logic error;
    logic busy;
    logic done;
  } ch_status_t;

  // Transfer cycle counter.
  localparam int                      CYCLES_WIDTH = 32;
  localparam logic [CYCLES_WIDTH-1:0] CYCLES_MAX   = 32'hFFFF_FFFF;

  // Low byte of the ID register identifies this register map revision.
  localparam logic [7:0] ID_TAG = 8'h02;

  // ID register contents: channel count in byte 1, map tag in byte 0.
  function automatic logic [63:0] id_word(input logic [7:0] num_ch);
    return {48'h0000_0000_0000, num_ch, ID_TAG};
  endfunction

endpackage

// File: rtl/mmio_if.sv
// mmio_if: HAL MMIO bus between host-side register access logic and an AFU
// register block.
//   wr_en/wr_addr/wr_data : single-cycle word write
//   rd_en/rd_addr         : single-cycle word read request
//   rd_data               : read data, registered by the user side
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  modport user (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );

  modport host (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/dma_mm_channel.sv
// dma_mm_channel: register set and status tracking for one DMA channel.
//   clk, rst_n      : clock, synchronous active-low reset
//   ctrl_we         : CTRL word written this cycle (wdata bit0 go, bit1 clear)
//   rd_addr_we      : RD_ADDR word written this cycle
//   wr_addr_we      : WR_ADDR word written this cycle
//   size_we         : SIZE word written this cycle
//   wdata           : MMIO write data
//   done            : completion pulse from the DMA engine
//   rd_addr/wr_addr : DMA start byte addresses (registered)
//   size            : cache-line count (registered)
//   go              : one-cycle start pulse (registered)
//   status          : done/busy/error flags
//   cycles          : cycles spent busy in the current/last transfer
module dma_mm_channel
  import dma_mm_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ctrl_we,
  input  logic                    rd_addr_we,
  input  logic                    wr_addr_we,
  input  logic                    size_we,
  input  logic [63:0]             wdata,
  input  logic                    done,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [SIZE_WIDTH-1:0]   size,
  output logic                    go,
  output ch_status_t              status,
  output logic [CYCLES_WIDTH-1:0] cycles
);

  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [SIZE_WIDTH-1:0]   size_r;
  logic                    go_r;
  logic                    busy_r;
  logic                    done_sticky_r;
  logic                    error_sticky_r;
  logic [CYCLES_WIDTH-1:0] cycles_r;

  logic                    accept_s;
  logic                    reject_s;
  logic                    clear_s;
  logic                    done_evt_s;
  logic                    busy_nxt_s;
  logic                    done_nxt_s;
  logic                    error_nxt_s;
  logic [CYCLES_WIDTH-1:0] cycles_nxt_s;

  // Event decode and next-state for busy, sticky flags and cycle counter.
  // busy is always judged on its current value, so a done pulse landing in
  // the same cycle as a go request still rejects that go.
  always_comb begin
    accept_s   = ctrl_we & wdata[CTRL_GO_BIT] & ~busy_r;
    reject_s   = ctrl_we & wdata[CTRL_GO_BIT] & busy_r;
    clear_s    = ctrl_we & wdata[CTRL_CLR_BIT];
    done_evt_s = done & busy_r;

    if (accept_s) begin
      busy_nxt_s = 1'b1;
    end else if (done_evt_s) begin
      busy_nxt_s = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end

    // Completion set beats a same-cycle clear.
    if (done_evt_s) begin
      done_nxt_s = 1'b1;
    end else if (accept_s || clear_s) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_sticky_r;
    end

    // A rejected go beats a same-cycle clear.
    if (reject_s) begin
      error_nxt_s = 1'b1;
    end else if (clear_s) begin
      error_nxt_s = 1'b0;
    end else begin
      error_nxt_s = error_sticky_r;
    end

    // Counts every cycle busy is high, including the cycle done arrives.
    if (accept_s) begin
      cycles_nxt_s = {CYCLES_WIDTH{1'b0}};
    end else if (busy_r && (cycles_r != CYCLES_MAX)) begin
      cycles_nxt_s = cycles_r + 32'd1;
    end else begin
      cycles_nxt_s = cycles_r;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_r      <= {ADDR_WIDTH{1'b0}};
      wr_addr_r      <= {ADDR_WIDTH{1'b0}};
      size_r         <= {SIZE_WIDTH{1'b0}};
      go_r           <= 1'b0;
      busy_r         <= 1'b0;
      done_sticky_r  <= 1'b0;
      error_sticky_r <= 1'b0;
      cycles_r       <= {CYCLES_WIDTH{1'b0}};
    end else begin
      if (rd_addr_we) begin
        rd_addr_r <= wdata[ADDR_WIDTH-1:0];
      end
      if (wr_addr_we) begin
        wr_addr_r <= wdata[ADDR_WIDTH-1:0];
      end
      if (size_we) begin
        size_r <= wdata[SIZE_WIDTH-1:0];
      end
      go_r           <= accept_s;
      busy_r         <= busy_nxt_s;
      done_sticky_r  <= done_nxt_s;
      error_sticky_r <= error_nxt_s;
      cycles_r       <= cycles_nxt_s;
    end
  end

  assign rd_addr      = rd_addr_r;
  assign wr_addr      = wr_addr_r;
  assign size         = size_r;
  assign go           = go_r;
  assign status.done  = done_sticky_r;
  assign status.busy  = busy_r;
  assign status.error = error_sticky_r;
  assign cycles       = cycles_r;

endmodule

// File: rtl/dma_memory_map.sv
// dma_memory_map: MMIO register map for NUM_CH independent DMA channels.
//   clk, rst_n : clock, synchronous active-low reset
//   mmio       : MMIO user port (writes decoded here, rd_data registered)
//   rd_addr    : per-channel DMA read start byte address
//   wr_addr    : per-channel DMA write start byte address
//   size       : per-channel cache-line count
//   go         : per-channel one-cycle start pulse
//   done       : per-channel completion pulse from the DMA engines
// Channel c occupies BASE_ADDR + CH_STRIDE*c; the ID word follows the last
// channel block.
module dma_memory_map
  import dma_mm_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 17,
  parameter logic [15:0] BASE_ADDR  = 16'h0050
) (
  input  logic                                clk,
  input  logic                                rst_n,
  mmio_if.user                                mmio,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   wr_addr,
  output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]   size,
  output logic [NUM_CH-1:0]                   go,
  input  logic [NUM_CH-1:0]                   done
);

  logic [15:0]                          wr_ofs_s;
  logic                                 wr_in_s;
  logic [NUM_CH-1:0]                    ctrl_we_s;
  logic [NUM_CH-1:0]                    rd_addr_we_s;
  logic [NUM_CH-1:0]                    wr_addr_we_s;
  logic [NUM_CH-1:0]                    size_we_s;
  logic [15:0]                          rd_ofs_s;
  logic [15:0]                          ch_base_s;
  logic [63:0]                          rd_mux_s;
  logic [63:0]                          rd_data_r;
  ch_status_t [NUM_CH-1:0]              status_s;
  logic [NUM_CH-1:0][CYCLES_WIDTH-1:0]  cycles_s;

  // Write decode: offset relative to the map base, one strobe per register.
  always_comb begin
    wr_ofs_s = mmio.wr_addr - BASE_ADDR;
    wr_in_s  = mmio.wr_en && (mmio.wr_addr >= BASE_ADDR);
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_we_s[c]    = wr_in_s && (wr_ofs_s == 16'(c) * CH_STRIDE + CTRL_OFS);
      rd_addr_we_s[c] = wr_in_s && (wr_ofs_s == 16'(c) * CH_STRIDE + RD_ADDR_OFS);
      wr_addr_we_s[c] = wr_in_s && (wr_ofs_s == 16'(c) * CH_STRIDE + WR_ADDR_OFS);
      size_we_s[c]    = wr_in_s && (wr_ofs_s == 16'(c) * CH_STRIDE + SIZE_OFS);
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
      dma_mm_channel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE_WIDTH (SIZE_WIDTH)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_we    (ctrl_we_s[gc]),
        .rd_addr_we (rd_addr_we_s[gc]),
        .wr_addr_we (wr_addr_we_s[gc]),
        .size_we    (size_we_s[gc]),
        .wdata      (mmio.wr_data),
        .done       (done[gc]),
        .rd_addr    (rd_addr[gc]),
        .wr_addr    (wr_addr[gc]),
        .size       (size[gc]),
        .go         (go[gc]),
        .status     (status_s[gc]),
        .cycles     (cycles_s[gc])
      );
    end
  endgenerate

  // Read mux over current register values; anything unmatched reads zero.
  always_comb begin
    rd_mux_s  = 64'h0;
    ch_base_s = 16'h0000;
    rd_ofs_s  = mmio.rd_addr - BASE_ADDR;
    if (mmio.rd_addr < BASE_ADDR) begin
      rd_mux_s = 64'h0;
    end else if (rd_ofs_s == 16'(NUM_CH) * CH_STRIDE) begin
      rd_mux_s = id_word(8'(NUM_CH));
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_base_s = 16'(c) * CH_STRIDE;
        case (rd_ofs_s)
          ch_base_s + RD_ADDR_OFS: rd_mux_s = 64'(rd_addr[c]);
          ch_base_s + WR_ADDR_OFS: rd_mux_s = 64'(wr_addr[c]);
          ch_base_s + SIZE_OFS:    rd_mux_s = 64'(size[c]);
          ch_base_s + STATUS_OFS:  rd_mux_s = {61'h0, status_s[c]};
          ch_base_s + CYCLES_OFS:  rd_mux_s = {32'h0, cycles_s[c]};
          default:                 rd_mux_s = rd_mux_s;
        endcase
      end
    end
  end

  // Read data register: captured on rd_en, held until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r <= 64'h0;
    end else if (mmio.rd_en) begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign mmio.rd_data = rd_data_r;

endmodule

// File: tb/tb_dma_memory_map.sv
module tb_dma_memory_map;

  localparam int          NUM_CH = 2;
  localparam int          AW     = 64;
  localparam int          SW     = 17;
  localparam logic [15:0] BASE   = 16'h0050;
  localparam logic [63:0] SZ_MASK = (64'd1 << SW) - 64'd1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_CH-1:0]          done_v = '0;
  logic [NUM_CH-1:0][AW-1:0]  rd_addr_o;
  logic [NUM_CH-1:0][AW-1:0]  wr_addr_o;
  logic [NUM_CH-1:0][SW-1:0]  size_o;
  logic [NUM_CH-1:0]          go_o;

  mmio_if bus();

  dma_memory_map #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mmio(bus),
    .rd_addr(rd_addr_o), .wr_addr(wr_addr_o), .size(size_o),
    .go(go_o), .done(done_v)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the architectural state of each channel.
  logic [63:0]       m_rda [NUM_CH];
  logic [63:0]       m_wra [NUM_CH];
  logic [63:0]       m_sz  [NUM_CH];
  bit                m_busy[NUM_CH];
  bit                m_dst [NUM_CH];
  bit                m_err [NUM_CH];
  logic [31:0]       m_cyc [NUM_CH];
  logic [NUM_CH-1:0] m_go;
  logic [63:0]       m_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [15:0] a);
    int rel, ch, off;
    if (a < BASE) return 64'h0;
    rel = int'(a) - int'(BASE);
    ch  = rel / 16;
    off = rel % 16;
    if (ch == NUM_CH) return (off == 0) ? {48'h0, 8'(NUM_CH), 8'h02} : 64'h0;
    if (ch > NUM_CH) return 64'h0;
    case (off)
      2:       return m_rda[ch];
      4:       return m_wra[ch];
      6:       return m_sz[ch];
      8:       return {61'h0, m_err[ch], m_busy[ch], m_dst[ch]};
      10:      return {32'h0, m_cyc[ch]};
      default: return 64'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven, let the
  // DUT take the same edge, then compare every output.
  task automatic tick();
    int  rel, wch, woff;
    bit  go_req, clr, busy0;
    m_go = '0;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_rda[c] = 64'h0; m_wra[c] = 64'h0; m_sz[c] = 64'h0;
        m_busy[c] = 1'b0; m_dst[c] = 1'b0; m_err[c] = 1'b0; m_cyc[c] = 32'h0;
      end
      m_rdata = 64'h0;
    end else begin
      if (bus.rd_en) m_rdata = model_read(bus.rd_addr);
      wch = -1; woff = -1;
      if (bus.wr_en && bus.wr_addr >= BASE) begin
        rel  = int'(bus.wr_addr) - int'(BASE);
        wch  = rel / 16;
        woff = rel % 16;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        go_req = (wch == c) && (woff == 0) && bus.wr_data[0];
        clr    = (wch == c) && (woff == 0) && bus.wr_data[1];
        busy0  = m_busy[c];
        if (busy0 && m_cyc[c] != 32'hFFFF_FFFF) m_cyc[c] = m_cyc[c] + 32'd1;
        if (clr) begin m_dst[c] = 1'b0; m_err[c] = 1'b0; end
        if (go_req) begin
          if (!busy0) begin
            m_busy[c] = 1'b1; m_dst[c] = 1'b0; m_cyc[c] = 32'h0; m_go[c] = 1'b1;
          end else begin
            m_err[c] = 1'b1;
          end
        end
        if (done_v[c] && busy0) begin m_busy[c] = 1'b0; m_dst[c] = 1'b1; end
        if (wch == c) begin
          case (woff)
            2:       m_rda[c] = bus.wr_data;
            4:       m_wra[c] = bus.wr_data;
            6:       m_sz[c]  = bus.wr_data & SZ_MASK;
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("rd_data", bus.rd_data, m_rdata);
    for (int c = 0; c < NUM_CH; c++) begin
      check_eq($sformatf("go%0d", c), {63'h0, go_o[c]}, {63'h0, m_go[c]});
      check_eq($sformatf("rd_addr%0d", c), rd_addr_o[c], m_rda[c]);
      check_eq($sformatf("wr_addr%0d", c), wr_addr_o[c], m_wra[c]);
      check_eq($sformatf("size%0d", c), 64'(size_o[c]), m_sz[c]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mm_write(input logic [15:0] a, input logic [63:0] d, input logic [NUM_CH-1:0] dn);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; done_v = dn;
    tick();
    bus.wr_en = 1'b0; done_v = '0;
  endtask

  task automatic mm_read(input logic [15:0] a);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_done(input logic [NUM_CH-1:0] dn);
    done_v = dn;
    tick();
    done_v = '0;
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom);
    return BASE + 16'($urandom_range(0, 16 * NUM_CH + 15));
  endfunction

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 16'h0; bus.wr_data = 64'h0;
    bus.rd_en = 1'b0; bus.rd_addr = 16'h0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Reset state and ID word.
    mm_read(16'h0058);
    check_eq("rst_status0", bus.rd_data, 64'h0);
    mm_read(16'h0070);
    check_eq("id", bus.rd_data, 64'h0000_0000_0000_0202);

    // Channel 1 transfer: exactly 20 busy cycles.
    mm_write(16'h0062, 64'hDEAD_BEEF_0000_1000, '0);
    mm_write(16'h0066, 64'd16, '0);
    mm_write(16'h0060, 64'h1, '0);
    check_eq("go1_pulse", {62'h0, go_o}, 64'h2);
    tick();
    check_eq("go1_once", {62'h0, go_o}, 64'h0);
    mm_read(16'h0068);
    check_eq("st1_busy", bus.rd_data, 64'h2);
    idle(17);
    pulse_done(2'b10);
    mm_read(16'h0068);
    check_eq("st1_done", bus.rd_data, 64'h1);
    mm_read(16'h006A);
    check_eq("cycles1", bus.rd_data, 64'd20);
    mm_read(16'h0062);
    check_eq("rdaddr1", bus.rd_data, 64'hDEAD_BEEF_0000_1000);

    // Go while busy is rejected; clear drops error only.
    mm_write(16'h0050, 64'h1, '0);
    mm_write(16'h0050, 64'h1, '0);
    check_eq("go0_rej", {62'h0, go_o}, 64'h0);
    mm_read(16'h0058);
    check_eq("st0_err", bus.rd_data, 64'h6);
    mm_write(16'h0050, 64'h2, '0);
    mm_read(16'h0058);
    check_eq("st0_clr", bus.rd_data, 64'h2);

    // Same-cycle done and go while busy.
    mm_write(16'h0050, 64'h1, 2'b01);
    check_eq("go0_same", {62'h0, go_o}, 64'h0);
    mm_read(16'h0058);
    check_eq("st0_same", bus.rd_data, 64'h5);

    // Idle done pulse, odd/unmapped/read-only writes, unmapped reads.
    pulse_done(2'b10);
    mm_write(16'h0063, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    mm_write(16'h0040, 64'h1234_5678_9ABC_DEF0, '0);
    mm_write(16'h0072, 64'h1, '0);
    mm_write(16'h0068, 64'h7, '0);
    mm_read(16'h0063);
    check_eq("rd_odd", bus.rd_data, 64'h0);
    mm_read(16'h0072);
    check_eq("rd_unmap", bus.rd_data, 64'h0);
    mm_read(16'h0062);
    check_eq("rdaddr1_keep", bus.rd_data, 64'hDEAD_BEEF_0000_1000);
    mm_read(16'h0068);
    check_eq("st1_keep", bus.rd_data, 64'h1);

    // Reset mid-transfer, then a stale done.
    mm_write(16'h0060, 64'h1, '0);
    idle(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_done(2'b10);
    mm_read(16'h0068);
    check_eq("st1_after_rst", bus.rd_data, 64'h0);
    check_eq("rdaddr1_rst", rd_addr_o[1], 64'h0);

    // Randomized traffic against the model.
    repeat (1500) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      bus.wr_en   = $urandom_range(0, 1) == 1;
      bus.wr_addr = pick_addr();
      bus.wr_data = {$urandom, $urandom};
      bus.rd_en   = $urandom_range(0, 1) == 1;
      bus.rd_addr = pick_addr();
      for (int c = 0; c < NUM_CH; c++) done_v[c] = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_n = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; done_v = '0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
